uart_mem_loader: RTL and testbench

- Bus initiator for the CPU's word-addressed data/instruction RAM; the writing end of the memory port.
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and issues single-cycle write strobes at consecutive word addresses.
- Used in programming mode to fill memory before the CPU is released.
- Emits memWrite/address/writeData in the same form the memory block accepts; the memory captures on the falling clock edge.

---
 rtl/uart_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_mem_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART-to-memory loader: takes a 16-bit little-endian word count followed by
// little-endian 32-bit words from a byte stream and writes them to consecutive
// word addresses starting at BASE_ADDR, one single-cycle write strobe per word.
module uart_mem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;      // lower three bytes of the word being assembled
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [31:0] timer_q, timer_d;

    logic [15:0] new_len;
    logic        timed_out;
    logic [15:0] count_inc;

    assign new_len   = {rx_data, len_q[7:0]};
    // True on the cycle that would complete TIMEOUT_CYCLES idle cycles.
    assign timed_out = (timer_q + 32'd1) >= TIMEOUT_CYCLES;
    assign count_inc = count_q + 16'd1;

    // Next-state logic for the loader FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        count_d    = count_q;
        timer_d    = timer_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // Bytes arriving here are dropped, including one coincident with start.
                if (start) begin
                    state_d    = S_LEN_LO;
                    addr_d     = BASE_ADDR;
                    count_d    = 16'd0;
                    timer_d    = 32'd0;
                    byte_idx_d = 2'd0;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    timer_d    = 32'd0;
                    state_d    = S_LEN_HI;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d      = new_len;
                    timer_d    = 32'd0;
                    byte_idx_d = 2'd0;
                    if (new_len == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({16'd0, new_len} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    timer_d    = 32'd0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            wdata_d = {rx_data, word_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WRITE: begin
                count_d = count_inc;
                timer_d = 32'd0;
                if (count_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    // A byte arriving during the write is the next word's byte 0.
                    addr_d  = addr_q + 32'd4;
                    state_d = S_DATA;
                    if (rx_valid) begin
                        word_d[7:0] = rx_data;
                        byte_idx_d  = 2'd1;
                    end else begin
                        byte_idx_d  = 2'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            word_q     <= 24'd0;
            wdata_q    <= 32'd0;
            addr_q     <= BASE_ADDR;
            count_q    <= 16'd0;
            timer_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
        end
    end

    // Status and bus outputs decoded from state.
    always_comb begin
        memWrite      = (state_q == S_WRITE);
        busy          = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_WRITE);
        done          = (state_q == S_DONE);
        error         = (state_q == S_ERROR);
        address       = addr_q;
        writeData     = wdata_q;
        words_written = count_q;
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: drives byte streams, records every
// memory write on the falling edge, and compares against expected writes queued
// alongside the stimulus.
module tb_uart_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int tests_run = 0;
    int fails = 0;

    logic [63:0] exp_q[$];   // {address, data} expected
    logic [63:0] obs_q[$];   // {address, data} observed
    logic [7:0]  tx_q[$];    // bytes to send
    logic [31:0] mem [0:15];

    uart_mem_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_WORDS      (16384),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .start         (start),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .memWrite      (memWrite),
        .address       (address),
        .writeData     (writeData),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Memory model: captures on the falling edge like the real RAM.
    always @(negedge clk) begin
        if (memWrite) begin
            obs_q.push_back({address, writeData});
            mem[address[5:2]] = writeData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Send queued bytes with 'gap' idle cycles between them.
    task automatic send_stream(input int gap);
        while (tx_q.size() > 0) begin
            rx_data  = tx_q.pop_front();
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic push_word(input logic [31:0] addr, input logic [31:0] w);
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[31:24]);
        exp_q.push_back({addr, w});
    endtask

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests_run++;
        if ({memWrite, busy, done, error} !== 4'b0 || address !== 32'h0 ||
            writeData !== 32'h0 || words_written !== 16'h0) begin
            fails++;
            $display("FAIL reset: mw=%b busy=%b done=%b err=%b addr=%h wd=%h ww=%0d, required all 0",
                     memWrite, busy, done, error, address, writeData, words_written);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_two();
        bit ok;
        pulse_start();
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL load2_busy: busy=%b required 1", busy);
        end
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        push_word(32'h0, 32'h1234_5678);
        push_word(32'h4, 32'hDEAD_BEEF);
        send_stream(1);
        wait_not_busy(ok);
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL load2_timeout: busy stuck at %b, required 0", busy);
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || words_written !== 16'd2) begin
            fails++;
            $display("FAIL load2_status: done=%b err=%b ww=%0d, required 1 0 2",
                     done, error, words_written);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL load2_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [63:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL load2_write: addr/data %h, required %h", o, e);
            end
        end
        tests_run++;
        if (mem[0] !== 32'h1234_5678 || mem[1] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL load2_readback: %h %h, required 12345678 deadbeef", mem[0], mem[1]);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        pulse_start();
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h00);
        push_word(32'h0, 32'h0000_0001);
        push_word(32'h4, 32'h0000_0002);
        push_word(32'h8, 32'h0000_0003);
        send_stream(0);
        wait_not_busy(ok);
        tests_run++;
        if (!ok || done !== 1'b1 || words_written !== 16'd3) begin
            fails++;
            $display("FAIL b2b_status: ok=%b done=%b ww=%0d, required 1 1 3",
                     ok, done, words_written);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [63:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_write: addr/data %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_zero_length();
        pulse_start();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_stream(0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || words_written !== 16'd0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL zero_len: done=%b busy=%b ww=%0d writes=%0d, required 1 0 0 0",
                     done, busy, words_written, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_bad_length();
        pulse_start();
        tests_run++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL bad_len_clear: done=%b required 0", done);
        end
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h40);
        send_stream(0);
        tests_run++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL bad_len: err=%b busy=%b done=%b writes=%0d, required 1 0 0 0",
                     error, busy, done, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        pulse_start();
        tests_run++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: err=%b required 0", error);
        end
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        send_stream(0);
        repeat (15) tick();
        tests_run++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: err=%b busy=%b after 15 cycles, required 0 1",
                     error, busy);
        end
        tick();
        tests_run++;
        if (error !== 1'b1 || busy !== 1'b0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_fire: err=%b busy=%b writes=%0d after 16 cycles, required 1 0 0",
                     error, busy, obs_q.size());
        end
        obs_q.delete();
        // Recovery with a complete stream.
        pulse_start();
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        push_word(32'h0, 32'hCAFE_F00D);
        send_stream(0);
        wait_not_busy(ok);
        tests_run++;
        if (!ok || done !== 1'b1 || error !== 1'b0 || words_written !== 16'd1) begin
            fails++;
            $display("FAIL timeout_recover: ok=%b done=%b err=%b ww=%0d, required 1 1 0 1",
                     ok, done, error, words_written);
        end
        tests_run++;
        if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            fails++;
            $display("FAIL timeout_recover_write: %0d writes (first %h), required 1 of %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, exp_q[0]);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_word();
        pulse_start();
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        send_stream(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({memWrite, busy, done, error} !== 4'b0 || address !== 32'h0 ||
            writeData !== 32'h0 || words_written !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: mw=%b busy=%b done=%b err=%b addr=%h wd=%h ww=%0d, required all 0",
                     memWrite, busy, done, error, address, writeData, words_written);
        end
        tx_q.push_back(8'h33);
        tx_q.push_back(8'h44);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        send_stream(0);
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_ignore: busy=%b done=%b err=%b writes=%0d, required 0 0 0 0",
                     busy, done, error, obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_load_two();
        test_back_to_back();
        test_zero_length();
        test_bad_length();
        test_timeout();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
